// File: rtl/vector_sequencer.sv
// Vector ROM player/checker: fetches {valid, inputs, expected} words, drives the
// block under test, waits SETTLE cycles, compares its output and tallies errors.
module vector_sequencer #(
    parameter int IN_W   = 3,
    parameter int OUT_W  = 1,
    parameter int ADDR_W = 14,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [IN_W+OUT_W:0]     rom_data,
    output logic [IN_W-1:0]         dut_in,
    input  logic [OUT_W-1:0]        dut_out,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [CNT_W-1:0]        vec_count,
    output logic [CNT_W-1:0]        err_count,
    output logic                    err_valid,
    output logic [ADDR_W-1:0]       err_index,
    output logic [OUT_W-1:0]        err_got,
    output logic [2:0]              dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_SETTLE = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t            state, state_nxt;
    logic [SW-1:0]     settle_cnt;
    logic [OUT_W-1:0]  exp_r;
    logic              rom_valid;
    logic              last_addr;
    logic              mismatch;

    assign rom_valid = rom_data[IN_W+OUT_W];
    assign last_addr = (rom_addr == {ADDR_W{1'b1}});
    assign mismatch  = (dut_out != exp_r);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // abort overrides every transition, including a simultaneous start
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:   if (start) state_nxt = S_FETCH;
                S_FETCH:  state_nxt = S_DECODE;
                S_DECODE: state_nxt = rom_valid ? S_SETTLE : S_DONE;
                S_SETTLE: if (settle_cnt == '0) state_nxt = S_CHECK;
                S_CHECK:  state_nxt = last_addr ? S_DONE : S_FETCH;
                S_DONE:   if (start) state_nxt = S_FETCH;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        dbg_state = state;
        unique case (state)
            S_FETCH, S_DECODE, S_SETTLE, S_CHECK: busy = 1'b1;
            S_DONE:                               done = 1'b1;
            default: ;
        endcase
        pass = done && (err_count == '0);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rom_addr   <= '0;
            dut_in     <= '0;
            exp_r      <= '0;
            settle_cnt <= '0;
            vec_count  <= '0;
            err_count  <= '0;
            err_valid  <= 1'b0;
            err_index  <= '0;
            err_got    <= '0;
        end else begin
            err_valid <= 1'b0;
            if (!abort) begin
                unique case (state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            rom_addr  <= '0;
                            vec_count <= '0;
                            err_count <= '0;
                            err_index <= '0;
                            err_got   <= '0;
                        end
                    end
                    S_DECODE: begin
                        if (rom_valid) begin
                            dut_in     <= rom_data[IN_W+OUT_W-1:OUT_W];
                            exp_r      <= rom_data[OUT_W-1:0];
                            settle_cnt <= SW'(SETTLE - 1);
                        end
                    end
                    S_SETTLE: begin
                        if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
                    end
                    S_CHECK: begin
                        vec_count <= vec_count + 1'b1;
                        if (mismatch) begin
                            err_valid <= 1'b1;
                            err_index <= rom_addr;
                            err_got   <= dut_out;
                            if (err_count != '1) err_count <= err_count + 1'b1;
                        end
                        // the last ROM address ends the run instead of wrapping
                        if (!last_addr) rom_addr <= rom_addr + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vector_sequencer.sv
// Directed bench for vector_sequencer: a 3-input AND as the block under test,
// a full-size instance (ADDR_W=14) and a small one (ADDR_W=3) for the wrap case.
module tb_vector_sequencer;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd3;

    int n_tests = 0;
    int n_fail  = 0;
    logic [13:0] exp_q[$];

    // clock / reset
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic start = 1'b0, abort = 1'b0;
    logic start3 = 1'b0, abort3 = 1'b0;

    // full-size instance
    logic [13:0] rom_addr, err_index;
    logic [4:0]  rom_data = '0;
    logic [2:0]  dut_in, dbg_state;
    logic        dut_out, busy, done, pass, err_valid, err_got;
    logic [31:0] vec_count, err_count;
    logic [4:0]  rom [16];

    // ADDR_W=3 instance
    logic [2:0]  rom_addr3, err_index3, dut_in3, dbg_state3;
    logic [4:0]  rom_data3 = '0;
    logic        dut_out3, busy3, done3, pass3, err_valid3, err_got3;
    logic [31:0] vec_count3, err_count3;
    logic [4:0]  rom3 [8];

    vector_sequencer #(.IN_W(3), .OUT_W(1), .ADDR_W(14), .SETTLE(1), .CNT_W(32)) u_dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .rom_addr(rom_addr), .rom_data(rom_data), .dut_in(dut_in), .dut_out(dut_out),
        .busy(busy), .done(done), .pass(pass), .vec_count(vec_count),
        .err_count(err_count), .err_valid(err_valid), .err_index(err_index),
        .err_got(err_got), .dbg_state(dbg_state)
    );

    vector_sequencer #(.IN_W(3), .OUT_W(1), .ADDR_W(3), .SETTLE(1), .CNT_W(32)) u_dut3 (
        .clock(clock), .reset(reset), .start(start3), .abort(abort3),
        .rom_addr(rom_addr3), .rom_data(rom_data3), .dut_in(dut_in3), .dut_out(dut_out3),
        .busy(busy3), .done(done3), .pass(pass3), .vec_count(vec_count3),
        .err_count(err_count3), .err_valid(err_valid3), .err_index(err_index3),
        .err_got(err_got3), .dbg_state(dbg_state3)
    );

    // synchronous ROMs (1-cycle latency) and the AND gate under test
    always @(posedge clock) begin
        rom_data  <= (rom_addr < 14'd16) ? rom[rom_addr[3:0]] : 5'd0;
        rom_data3 <= rom3[rom_addr3];
    end
    assign dut_out  = &dut_in;
    assign dut_out3 = &dut_in3;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard: each err_valid pulse must match the next expected err_index
    always @(negedge clock) begin
        logic [13:0] e;
        if (reset && err_valid) begin
            if (exp_q.size() == 0) begin
                check("err_valid_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("err_index_pulse", 32'(err_index), 32'(e));
            end
        end
        if (reset && err_valid3) check("t5_err_valid", 32'(err_valid3), 32'd0);
    end

    // driver tasks
    task automatic load_rom(input int flip, input bit empty);
        for (int i = 0; i < 16; i++) begin
            logic [2:0] a;
            a = i[2:0];
            rom[i] = (i < 8) ? {1'b1, a, &a} : 5'd0;
            if (i == flip) rom[i][0] = ~rom[i][0];
        end
        if (empty) rom[0] = 5'd0;
    endtask

    task automatic pulse_start(input int which);
        @(negedge clock);
        if (which == 0) start = 1'b1; else start3 = 1'b1;
        @(negedge clock);
        start  = 1'b0;
        start3 = 1'b0;
    endtask

    // counts rising edges from the start edge until done is observed
    task automatic wait_done(input int which, input int budget, output int n);
        n = 0;
        while (!(which == 0 ? done : done3) && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (n >= budget) check("wait_done_timeout", 32'(n), 32'(budget - 1));
    endtask

    task automatic wait_settle(input logic [13:0] addr, input int budget);
        int n;
        n = 0;
        while (!(dbg_state == S_SETTLE && rom_addr == addr) && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (n >= budget) check("wait_settle_timeout", 32'(n), 32'(budget - 1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] a;
            a = i[2:0];
            rom3[i] = {1'b1, a, &a};
        end
        load_rom(-1, 1'b0);

        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst_state", 32'(dbg_state), 32'(S_IDLE));
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done_pass", 32'({done, pass}), 32'd0);
        check("rst_addr", 32'(rom_addr), 32'd0);

        // 8 matching AND vectors, end marker at word 8: 8*4 + FETCH + DECODE
        pulse_start(0);
        check("t2_busy", 32'(busy), 32'd1);
        wait_done(0, 100, n);
        check("t2_latency", 32'(n), 32'd34);
        check("t2_vec_count", vec_count, 32'd8);
        check("t2_err_count", err_count, 32'd0);
        check("t2_pass", 32'(pass), 32'd1);
        check("t2_busy_end", 32'(busy), 32'd0);

        // vector 5 expects 1 but AND(1,0,1)=0
        load_rom(5, 1'b0);
        exp_q.push_back(14'd5);
        pulse_start(0);
        wait_done(0, 100, n);
        check("t3_latency", 32'(n), 32'd34);
        check("t3_vec_count", vec_count, 32'd8);
        check("t3_err_count", err_count, 32'd1);
        check("t3_err_index", 32'(err_index), 32'd5);
        check("t3_err_got", 32'(err_got), 32'd0);
        check("t3_pass", 32'(pass), 32'd0);
        check("t3_done", 32'(done), 32'd1);
        check("t3_pulses", 32'(exp_q.size()), 32'd0);

        // asynchronous reset in the middle of vector 2's SETTLE
        load_rom(-1, 1'b0);
        pulse_start(0);
        wait_settle(14'd2, 50);
        check("t1_pre_vec", vec_count, 32'd2);
        check("t1_pre_din", 32'(dut_in), 32'd2);
        #1 reset = 1'b0;
        #1;
        check("t1_state", 32'(dbg_state), 32'(S_IDLE));
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_addr", 32'(rom_addr), 32'd0);
        check("t1_din", 32'(dut_in), 32'd0);
        check("t1_vec", vec_count, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        pulse_start(0);
        check("t1_restart_state", 32'(dbg_state), 32'(S_FETCH));
        check("t1_restart_addr", 32'(rom_addr), 32'd0);
        wait_done(0, 100, n);
        check("t1_latency", 32'(n), 32'd34);
        check("t1_vec_count", vec_count, 32'd8);

        // empty ROM: word 0 invalid
        load_rom(-1, 1'b1);
        pulse_start(0);
        wait_done(0, 20, n);
        check("t4_latency", 32'(n), 32'd2);
        check("t4_vec_count", vec_count, 32'd0);
        check("t4_pass", 32'(pass), 32'd1);

        // abort during vector 3, then start+abort together in IDLE
        load_rom(-1, 1'b0);
        pulse_start(0);
        wait_settle(14'd3, 50);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("t6_state", 32'(dbg_state), 32'(S_IDLE));
        check("t6_done", 32'(done), 32'd0);
        check("t6_vec_count", vec_count, 32'd3);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clock);
        start = 1'b0;
        abort = 1'b0;
        @(negedge clock);
        check("t6_both_state", 32'(dbg_state), 32'(S_IDLE));
        check("t6_both_vec", vec_count, 32'd3);
        check("t6_both_addr", 32'(rom_addr), 32'd3);

        // ADDR_W=3: all words valid, run ends after address 7 without wrapping
        pulse_start(1);
        wait_done(1, 100, n);
        check("t5_latency", 32'(n), 32'd32);
        check("t5_vec_count", vec_count3, 32'd8);
        check("t5_addr", 32'(rom_addr3), 32'd7);
        check("t5_pass", 32'(pass3), 32'd1);
        repeat (3) @(negedge clock);
        check("t5_hold_done", 32'({done3, busy3}), 32'b10);
        check("t5_hold_vec", vec_count3, 32'd8);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
